// File: rtl/fp_acc_stream.sv
// Streaming floating-point accumulator: sums one valid-qualified product per cycle into a
// single feedback register and hands each completed frame sum downstream over valid/ready.
module fp_acc_stream #(
    parameter int EXPONENT  = 8,
    parameter int MANTISSA  = 23,
    parameter int CNT_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [EXPONENT+MANTISSA:0]   in_data,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [EXPONENT+MANTISSA:0]   out_data,
    output logic [CNT_WIDTH-1:0]         out_count
);

    localparam int W       = EXPONENT + MANTISSA + 1;
    localparam int SW      = MANTISSA + 3;
    localparam int SHW     = $clog2(SW);
    localparam int EXP_MAX = (1 << EXPONENT) - 1;

    localparam logic [0:0] ST_ACC  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]           state;
    logic                 first;
    logic [W-1:0]         acc;
    logic [W-1:0]         acc_next;
    logic [W-1:0]         sum_res;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_next;

    logic                 zero_a;
    logic                 zero_b;
    logic                 swap;
    logic [W-1:0]         op_l;
    logic [W-1:0]         op_s;
    logic [EXPONENT-1:0]  diff;
    logic [SW-1:0]        sig_l;
    logic [SW-1:0]        sig_s;
    logic [SW-1:0]        sig_al;
    logic [SW:0]          raw;
    logic [SHW-1:0]       shift;
    logic [SW-1:0]        norm;
    logic [SW:0]          rounded;
    logic [MANTISSA-1:0]  frac_r;
    int                   exp_n;
    int                   exp_r;
    logic                 unused_round_bits;

    assign zero_a   = (acc[W-2:MANTISSA] == '0);
    assign zero_b   = (in_data[W-2:MANTISSA] == '0);
    assign in_ready = (state == ST_ACC);

    // Significands carry two guard bits below the stored fraction; the smaller one is truncated on alignment.
    always_comb begin
        swap   = in_data[W-2:0] > acc[W-2:0];
        op_l   = swap ? in_data : acc;
        op_s   = swap ? acc : in_data;
        diff   = op_l[W-2:MANTISSA] - op_s[W-2:MANTISSA];
        sig_l  = {1'b1, op_l[MANTISSA-1:0], 2'b00};
        sig_s  = {1'b1, op_s[MANTISSA-1:0], 2'b00};
        sig_al = (int'(diff) >= SW) ? '0 : (sig_s >> diff);
        if (op_l[W-1] == op_s[W-1]) begin
            raw = {1'b0, sig_l} + {1'b0, sig_al};
        end else begin
            raw = {1'b0, sig_l} - {1'b0, sig_al};
        end
    end

    always_comb begin
        shift = '0;
        for (int i = 0; i < SW; i++) begin
            if (raw[i]) begin
                shift = SHW'(SW - 1 - i);
            end
        end
    end

    always_comb begin
        if (raw[SW]) begin
            norm  = raw[SW:1];
            exp_n = int'(op_l[W-2:MANTISSA]) + 1;
        end else begin
            norm  = raw[SW-1:0] << shift;
            exp_n = int'(op_l[W-2:MANTISSA]) - int'(shift);
        end
        rounded = {1'b0, norm} + (SW+1)'(2);
        exp_r   = exp_n + int'(rounded[SW]);
        frac_r  = rounded[SW] ? rounded[SW-1:3] : rounded[SW-2:2];
    end

    // Guard bits below the rounding point never reach the stored fraction.
    assign unused_round_bits = ^rounded[1:0];

    always_comb begin
        sum_res = {op_l[W-1], exp_r[EXPONENT-1:0], frac_r};
        if (exp_r >= EXP_MAX) begin
            sum_res = {op_l[W-1], {(W-1){1'b1}}};
        end else if (exp_r <= 0) begin
            sum_res = {op_l[W-1], {(W-1){1'b0}}};
        end
        if (raw == '0) begin
            sum_res = '0;
        end
        if (zero_b) begin
            sum_res = acc;
        end
        if (zero_a) begin
            sum_res = in_data;
        end
        if (zero_a && zero_b) begin
            sum_res = '0;
        end
    end

    assign acc_next = first ? in_data : sum_res;
    assign cnt_next = first ? CNT_WIDTH'(1) : cnt + CNT_WIDTH'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_ACC;
            first     <= 1'b1;
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
        end else begin
            case (state)
                ST_ACC: begin
                    if (in_valid) begin
                        acc   <= acc_next;
                        cnt   <= cnt_next;
                        first <= in_last;
                        if (in_last) begin
                            out_data  <= acc_next;
                            out_count <= cnt_next;
                            out_valid <= 1'b1;
                            state     <= ST_HOLD;
                        end
                    end
                end
                default: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_ACC;
                    end
                end
            endcase
        end
    end

endmodule
